// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with an integrated instruction
// register, IDCODE and BYPASS data registers, and a one-hot select for up to
// USER_COUNT external user data registers.
//
// Ports:
//   TCK        test clock; FSM and registers on rising edge, TDO on falling edge
//   TRST       asynchronous active-low reset
//   TMS, TDI   mode select / serial data in, sampled on rising TCK
//   TDO        serial data out (falling-edge retimed), TDO_OE its drive enable
//   STATE      current FSM state (0 = Test-Logic-Reset ... 15 = Update-IR)
//   IR         active instruction
//   USER_SEL   one-hot user DR select, all-zero when no user opcode is active
//   CAPTURE_DR, SHIFT_DR, UPDATE_DR  DR strobes, decoded from STATE
//   USER_TDI   TDI forwarded to the user chains
//   USER_TDO   serial outputs of the user chains
module jtag_tap_ctrl #(
  parameter int unsigned           IR_WIDTH      = 4,
  parameter logic [31:0]           IDCODE_VALUE  = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0]   IDCODE_OPCODE = 4'b0001,
  parameter logic [IR_WIDTH-1:0]   USER_BASE     = 4'b1000,
  parameter int unsigned           USER_COUNT    = 4
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  TDO_OE,
  output logic [3:0]            STATE,
  output logic [IR_WIDTH-1:0]   IR,
  output logic [USER_COUNT-1:0] USER_SEL,
  output logic                  CAPTURE_DR,
  output logic                  SHIFT_DR,
  output logic                  UPDATE_DR,
  output logic                  USER_TDI,
  input  logic [USER_COUNT-1:0] USER_TDO
);

  localparam logic [3:0] ST_TLR       = 4'd0;
  localparam logic [3:0] ST_RTI       = 4'd1;
  localparam logic [3:0] ST_SEL_DR    = 4'd2;
  localparam logic [3:0] ST_CAP_DR    = 4'd3;
  localparam logic [3:0] ST_SHIFT_DR  = 4'd4;
  localparam logic [3:0] ST_EXIT1_DR  = 4'd5;
  localparam logic [3:0] ST_PAUSE_DR  = 4'd6;
  localparam logic [3:0] ST_EXIT2_DR  = 4'd7;
  localparam logic [3:0] ST_UPD_DR    = 4'd8;
  localparam logic [3:0] ST_SEL_IR    = 4'd9;
  localparam logic [3:0] ST_CAP_IR    = 4'd10;
  localparam logic [3:0] ST_SHIFT_IR  = 4'd11;
  localparam logic [3:0] ST_EXIT1_IR  = 4'd12;
  localparam logic [3:0] ST_PAUSE_IR  = 4'd13;
  localparam logic [3:0] ST_EXIT2_IR  = 4'd14;
  localparam logic [3:0] ST_UPD_IR    = 4'd15;

  localparam int unsigned         IRW1       = IR_WIDTH + 1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic [3:0]            state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
  logic [31:0]           idcode_q, idcode_d;
  logic                  bypass_q, bypass_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_oe_q, tdo_oe_d;

  logic [IR_WIDTH-1:0]   ir_eff;
  logic                  sel_idcode;
  logic                  sel_user;
  logic                  sel_bypass;
  logic [USER_COUNT-1:0] user_sel;
  logic                  in_shift_dr;
  logic                  in_shift_ir;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_d = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_d = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  // While in TLR the visible instruction is forced to IDCODE at once, so the
  // reset value appears on the same edge that enters TLR; ir_q catches up on
  // the edge leaving it.
  always_comb begin
    ir_eff     = (state_q == ST_TLR) ? IDCODE_OPCODE : ir_q;
    sel_idcode = (ir_eff == IDCODE_OPCODE);
    user_sel   = '0;
    // Compare one bit wider so a user range running past the top opcode
    // cannot wrap around and alias low opcodes.
    for (int unsigned i = 0; i < USER_COUNT; i++) begin
      user_sel[i] = !sel_idcode &&
                    ({1'b0, ir_eff} == ({1'b0, USER_BASE} + IRW1'(i)));
    end
    sel_user   = |user_sel;
    sel_bypass = !sel_idcode && !sel_user;
  end

  assign in_shift_dr = (state_q == ST_SHIFT_DR);
  assign in_shift_ir = (state_q == ST_SHIFT_IR);

  // ---------------------------------------------------------------------------
  // Register datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_shift_d = ir_shift_q;
    if (state_q == ST_CAP_IR) begin
      ir_shift_d = IR_CAPTURE;
    end else if (in_shift_ir) begin
      ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
    end

    ir_d = ir_q;
    if (state_q == ST_TLR) begin
      ir_d = IDCODE_OPCODE;
    end else if (state_q == ST_UPD_IR) begin
      ir_d = ir_shift_q;
    end

    idcode_d = idcode_q;
    bypass_d = bypass_q;
    if (state_q == ST_CAP_DR) begin
      idcode_d = IDCODE_VALUE;
      bypass_d = 1'b0;
    end else if (in_shift_dr) begin
      if (sel_idcode) idcode_d = {TDI, idcode_q[31:1]};
      if (sel_bypass) bypass_d = TDI;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q    <= ST_TLR;
      ir_q       <= IDCODE_OPCODE;
      ir_shift_q <= '0;
      idcode_q   <= '0;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      idcode_q   <= idcode_d;
      bypass_q   <= bypass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TDO mux and falling-edge retiming
  // ---------------------------------------------------------------------------
  always_comb begin
    tdo_d    = 1'b0;
    tdo_oe_d = in_shift_ir || in_shift_dr;
    if (in_shift_ir) begin
      tdo_d = ir_shift_q[0];
    end else if (in_shift_dr) begin
      if (sel_idcode)    tdo_d = idcode_q[0];
      else if (sel_user) tdo_d = |(USER_TDO & user_sel);
      else               tdo_d = bypass_q;
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign TDO        = tdo_q;
  assign TDO_OE     = tdo_oe_q;
  assign STATE      = state_q;
  assign IR         = ir_eff;
  assign USER_SEL   = user_sel;
  assign CAPTURE_DR = (state_q == ST_CAP_DR);
  assign SHIFT_DR   = in_shift_dr;
  assign UPDATE_DR  = (state_q == ST_UPD_DR);
  assign USER_TDI   = TDI;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed-vector bench for jtag_tap_ctrl with
// hand-computed expected values.
module tb_jtag_tap_ctrl;

  logic       tck;
  logic       trst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_oe;
  logic [3:0] state;
  logic [3:0] ir;
  logic [3:0] user_sel;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       user_tdi;
  logic [3:0] user_tdo;

  int unsigned n_vec;
  int unsigned n_err;

  jtag_tap_ctrl #(
    .IR_WIDTH      (4),
    .IDCODE_VALUE  (32'h1000_0001),
    .IDCODE_OPCODE (4'b0001),
    .USER_BASE     (4'b1000),
    .USER_COUNT    (4)
  ) dut (
    .TCK        (tck),
    .TRST       (trst),
    .TMS        (tms),
    .TDI        (tdi),
    .TDO        (tdo),
    .TDO_OE     (tdo_oe),
    .STATE      (state),
    .IR         (ir),
    .USER_SEL   (user_sel),
    .CAPTURE_DR (capture_dr),
    .SHIFT_DR   (shift_dr),
    .UPDATE_DR  (update_dr),
    .USER_TDI   (user_tdi),
    .USER_TDO   (user_tdo)
  );

  initial tck = 1'b0;
  always #10 tck = ~tck;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive TMS/TDI, take one rising edge, then settle past the falling edge so
  // both the new STATE and the freshly retimed TDO are observable.
  task automatic step(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI: load an instruction, returning the bits seen on TDO during the
  // IR shift and the IR value visible while sitting in Update-IR.
  task automatic load_ir(input logic [3:0] val, output logic [3:0] cap,
                         output logic [3:0] ir_at_upd);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      step(i == 3, val[i]);
    end
    step(1'b1, 1'b0);
    ir_at_upd = ir;
    step(1'b0, 1'b0);
  endtask

  logic [31:0] got32;
  logic [8:0]  got9;
  logic [3:0]  cap;
  logic [3:0]  ir_upd;
  int          upd_cnt;

  // Walk through the DR path with a user register selected.
  logic [8:0] walk_tms  = 9'b0_1101_0100; // bit i applied at step i
  logic [3:0] walk_st [9] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd4, 4'd5, 4'd8, 4'd1};
  logic [3:0] walk_ut [9] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                              4'b1011, 4'b0000, 4'b0000, 4'b0000};
  logic [8:0] walk_tdo  = 9'b0_0000_0010;
  logic [8:0] walk_oe   = 9'b0_0010_0010;

  // TMS paths from Test-Logic-Reset to each state, applied LSB first.
  logic [7:0] nav_path [16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                                8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  int         nav_len  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};

  initial begin
    n_vec    = 0;
    n_err    = 0;
    trst     = 1'b0;
    tms      = 1'b1;
    tdi      = 1'b0;
    user_tdo = '0;

    // Reset state
    #5;
    check_eq("rst_state", {28'd0, state}, 32'd0);
    check_eq("rst_ir", {28'd0, ir}, 32'h1);
    check_eq("rst_tdo_oe", {30'd0, tdo, tdo_oe}, 32'd0);
    check_eq("rst_user_sel", {28'd0, user_sel}, 32'd0);
    check_eq("rst_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
    @(negedge tck);
    #1;
    trst = 1'b1;
    step(1'b0, 1'b0);
    check_eq("rti_state", {28'd0, state}, 32'd1);
    check_eq("rti_ir", {28'd0, ir}, 32'h1);
    check_eq("rti_tdo_oe", {31'd0, tdo_oe}, 32'd0);

    // IDCODE readout
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("cap_dr_state", {28'd0, state}, 32'd3);
    check_eq("cap_dr_strobe", {31'd0, capture_dr}, 32'd1);
    check_eq("cap_dr_oe", {31'd0, tdo_oe}, 32'd0);
    step(1'b0, 1'b0);
    check_eq("shift_dr_strobe", {31'd0, shift_dr}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      got32[i] = tdo;
      if (i == 0 || i == 31) check_eq("idcode_oe_in_shift", {31'd0, tdo_oe}, 32'd1);
      step(i == 31, 1'b0);
    end
    check_eq("idcode_value", got32, 32'h1000_0001);
    check_eq("idcode_exit1_state", {28'd0, state}, 32'd5);
    check_eq("idcode_oe_after", {31'd0, tdo_oe}, 32'd0);
    step(1'b1, 1'b0);
    check_eq("idcode_update_strobe", {31'd0, update_dr}, 32'd1);
    step(1'b0, 1'b0);

    // BYPASS through an all-ones instruction
    load_ir(4'b1111, cap, ir_upd);
    check_eq("ir_capture_bits", {30'd0, cap[1:0]}, 32'h1);
    check_eq("ir_held_in_update", {28'd0, ir_upd}, 32'h1);
    check_eq("ir_bypass_loaded", {28'd0, ir}, 32'hF);
    check_eq("bypass_user_sel", {28'd0, user_sel}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] pat;
      pat = 8'hA5;
      got9[i] = tdo;
      step(i == 8, (i < 8) ? pat[i] : 1'b0);
    end
    check_eq("bypass_stream", {23'd0, got9}, 32'h14A);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // User register 2 and the pause / Exit2 return path
    load_ir(4'b1010, cap, ir_upd);
    check_eq("user_ir_held_in_update", {28'd0, ir_upd}, 32'hF);
    check_eq("user_ir_loaded", {28'd0, ir}, 32'hA);
    check_eq("user_sel_onehot", {28'd0, user_sel}, 32'h4);
    step(1'b1, 1'b0);
    upd_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      user_tdo = walk_ut[i];
      step(walk_tms[i], 1'b0);
      check_eq($sformatf("walk_state_%0d", i), {28'd0, state}, {28'd0, walk_st[i]});
      check_eq($sformatf("walk_tdo_%0d", i), {31'd0, tdo}, {31'd0, walk_tdo[i]});
      check_eq($sformatf("walk_oe_%0d", i), {31'd0, tdo_oe}, {31'd0, walk_oe[i]});
      if (update_dr) upd_cnt++;
    end
    check_eq("walk_update_count", upd_cnt, 32'd1);
    check_eq("walk_user_sel_kept", {28'd0, user_sel}, 32'h4);
    user_tdo = '0;

    // Five TMS=1 edges from every state reach TLR
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
      for (int k = 0; k < nav_len[s]; k++) step(nav_path[s][k], 1'b1);
      check_eq($sformatf("nav_state_%0d", s), {28'd0, state}, s);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
      check_eq($sformatf("tlr_state_from_%0d", s), {28'd0, state}, 32'd0);
      check_eq($sformatf("tlr_ir_from_%0d", s), {28'd0, ir}, 32'h1);
    end

    // Asynchronous TRST in the middle of an IR shift
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("mid_shift_ir_state", {28'd0, state}, 32'd11);
    check_eq("mid_shift_ir_oe", {31'd0, tdo_oe}, 32'd1);
    #3;
    trst = 1'b0;
    #1;
    check_eq("trst_state", {28'd0, state}, 32'd0);
    check_eq("trst_ir", {28'd0, ir}, 32'h1);
    check_eq("trst_tdo_oe", {30'd0, tdo, tdo_oe}, 32'd0);
    check_eq("trst_user_sel", {28'd0, user_sel}, 32'd0);
    @(negedge tck);
    #1;
    trst = 1'b1;
    step(1'b1, 1'b0);
    check_eq("post_trst_hold_tlr", {28'd0, state}, 32'd0);
    step(1'b0, 1'b0);
    check_eq("post_trst_rti", {28'd0, state}, 32'd1);
    check_eq("post_trst_ir", {28'd0, ir}, 32'h1);
    check_eq("post_trst_user_sel", {28'd0, user_sel}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
